ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit. It generates the PC and issues one fetch at a time to the instruction memory over a req/gnt/rvalid handshake. It delivers each fetched {pc, instruction} pair to the IF/ID pipeline register. It is the upstream end of the IF/ID interface and honours jump (flush) and hold requests from ctrl.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- ifu_mem_req_o  out  1  fetch request; combinational from state
- ifu_mem_addr_o  out  `PORT_ADDR_WIDTH  fetch address; always equals the internal PC
- ifu_mem_gnt_i  in  1  request accepted this cycle
- ifu_mem_rvalid_i  in  1  read data valid; at least 1 cycle after gnt
- ifu_mem_rdata_i  in  `PORT_DATA_WIDTH  instruction word
- ifu_jump_flag_i  in  1  ctrl redirect; also flushes in-flight work
- ifu_jump_addr_i  in  `PORT_ADDR_WIDTH  redirect target
- ifu_hold_flag_i  in  1  ctrl stall; freezes outputs, blocks new requests
- ifu_pc_o  out  `PORT_ADDR_WIDTH  PC of delivered instruction, to IF/ID register
- ifu_inst_data_o  out  `PORT_DATA_WIDTH  delivered instruction; `INST_NOP when bubble
- ifu_inst_valid_o  out  1  delivered instruction valid
- ifu_misalign_o  out  1  misaligned-jump pulse (see Configuration)
- ifu_misalign_addr_o  out  `PORT_ADDR_WIDTH  offending jump address

## Operation
- States:
  - S_IDLE: reset state.
  - S_REQ: request pending.
  - S_WAIT: one request outstanding.
  - S_FULL: response parked in the skid buffer while held.
- At most one outstanding request.
- Reset values:
  - State S_IDLE; pc_q = RESET_PC.
  - ifu_mem_req_o = 0.
  - ifu_pc_o = 0, ifu_inst_data_o = `INST_NOP (32'h0000_0013), ifu_inst_valid_o = 0.
  - kill_q = 0; skid empty; misalign outputs = 0.
- S_IDLE: go to S_REQ unconditionally on the first clock after reset release.
- S_REQ:
  - ifu_mem_req_o = !jump && !hold.
  - On gnt, go to S_WAIT; pc_q is held.
  - On jump: pc_q <= jump_addr and stay in S_REQ. gnt is ignored because req is low.
- S_WAIT:
  - On rvalid with no kill_q, no jump and no hold: output regs <= {pc_q, rdata, valid=1}, pc_q <= pc_q+4, go to S_REQ.
  - On rvalid with hold (and no jump/kill): skid <= {pc_q, rdata}, pc_q <= pc_q+4, go to S_FULL.
  - Jump without rvalid: pc_q <= jump_addr, kill_q <= 1, stay in S_WAIT.
  - rvalid with kill_q or jump: discard the data, clear kill_q, go to S_REQ. On a same-cycle jump, pc_q <= jump_addr.
- S_FULL:
  - When hold drops: output <= skid with valid=1, go to S_REQ.
  - Jump: discard skid, pc_q <= jump_addr, go to S_REQ.
- Output register update, in priority order:
  1. Jump (overrides hold): bubble, i.e. valid <= 0 and inst <= NOP; pc_o is unchanged.
  2. Hold: freeze all outputs.
  3. Delivery: load as described above.
  4. Otherwise: bubble.
- PC arithmetic: pc_q + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Zero-wait memory (gnt in the req cycle, rvalid in the next cycle):
  - Request in cycle N; rvalid in N+1; ifu_inst_valid_o high in N+2.
  - The next request is issued in N+2.
  - Throughput is 1 instruction per 2 cycles.
- First request is issued in cycle 1 after rst_n rises.
- Jump has 1-cycle output latency: a bubble is presented the cycle after jump is asserted.
- The request to jump_addr:
  - From S_REQ: in the cycle after the jump.
  - From S_WAIT: in the cycle after the stale rvalid.
- rst_n asserted mid-transaction: all state clears immediately. A late rvalid arriving in S_IDLE is ignored.

## Configuration
- IFU_MISALIGN_CHK_EN defined:
  - A jump with jump_addr[1:0] != 0 pulses ifu_misalign_o for 1 cycle, registered.
  - ifu_misalign_addr_o is loaded with the raw target and holds its value until the next misaligned jump.
  - pc_q <= {jump_addr[31:2], 2'b00}.
- Undefined:
  - The same alignment truncation applies silently.
  - ifu_misalign_o and ifu_misalign_addr_o are tied to 0.

## Structure
- In define.v:
  - `PORT_ADDR_WIDTH, `PORT_DATA_WIDTH, `WORD_WIDTH.
  - `INST_NOP (32'h0000_0013).
  - State encodings `IFU_S_IDLE/REQ/WAIT/FULL (2 bits).
- Sub-module ifu_skid_buf: 1-entry {pc, inst} buffer with load, drain and flush inputs and a full flag, asynchronous reset to empty.

## Test plan
- Reset release, zero-wait memory returning addr+0x100 as data:
  - Requests go to 0x0, 0x4, 0x8.
  - Outputs valid every 2nd cycle: pc 0x0/inst 0x100, then 0x4/0x104.
- Jump to 0x80 while in S_WAIT, with rvalid 3 cycles later:
  - The stale data is never valid at the output.
  - The next request goes to 0x80.
- Hold asserted at rvalid for PC 0x8 and held 4 cycles:
  - Outputs stay frozen and no new requests are issued.
  - After hold drops, 0x8 is output for 1 cycle with valid=1, then a request to 0xC follows.
- Jump to 0x40 while in S_FULL with hold still high:
  - The skid is discarded and a bubble is output.
  - A request to 0x40 follows.
- Jump to 0x42:
  - With IFU_MISALIGN_CHK_EN: ifu_misalign_o pulses, ifu_misalign_addr_o = 0x42, next fetch is at 0x40.
  - Without it: no pulse, next fetch is at 0x40.
- Sequential fetch reaching pc 0xFFFF_FFFC: the next request wraps to 0x0.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared widths, constants, state encoding and helpers for the fetch unit
package ifu_fetch_pkg;

    localparam int PORT_ADDR_WIDTH = 32;
    localparam int PORT_DATA_WIDTH = 32;
    localparam int WORD_WIDTH      = 32;

    localparam logic [PORT_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [PORT_ADDR_WIDTH-1:0] PC_STEP  = PORT_ADDR_WIDTH'(WORD_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } ifu_state_e;

    // Jump targets are forced onto a word boundary before they become the PC.
    function automatic logic [PORT_ADDR_WIDTH-1:0] align_word(input logic [PORT_ADDR_WIDTH-1:0] a);
        return a & ~PORT_ADDR_WIDTH'(3);
    endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// rtl/ifu_skid_buf.sv - one-entry {pc, inst} buffer that parks a response while the pipeline is held
module ifu_skid_buf
    import ifu_fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic                       i_drain,
    input  logic                       i_flush,
    input  logic [PORT_ADDR_WIDTH-1:0] i_pc,
    input  logic [PORT_DATA_WIDTH-1:0] i_inst,
    output logic                       o_full,
    output logic [PORT_ADDR_WIDTH-1:0] o_pc,
    output logic [PORT_DATA_WIDTH-1:0] o_inst
);

    logic                       r_full;
    logic [PORT_ADDR_WIDTH-1:0] r_pc;
    logic [PORT_DATA_WIDTH-1:0] r_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_pc   <= '0;
            r_inst <= INST_NOP;
        end else if (i_flush || i_drain) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end
    end

    assign o_full = r_full;
    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit with jump/hold handling; IFU_MISALIGN_CHK_EN enables misaligned-jump reporting
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [PORT_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       ifu_mem_req_o,
    output logic [PORT_ADDR_WIDTH-1:0] ifu_mem_addr_o,
    input  logic                       ifu_mem_gnt_i,
    input  logic                       ifu_mem_rvalid_i,
    input  logic [PORT_DATA_WIDTH-1:0] ifu_mem_rdata_i,
    input  logic                       ifu_jump_flag_i,
    input  logic [PORT_ADDR_WIDTH-1:0] ifu_jump_addr_i,
    input  logic                       ifu_hold_flag_i,
    output logic [PORT_ADDR_WIDTH-1:0] ifu_pc_o,
    output logic [PORT_DATA_WIDTH-1:0] ifu_inst_data_o,
    output logic                       ifu_inst_valid_o,
    output logic                       ifu_misalign_o,
    output logic [PORT_ADDR_WIDTH-1:0] ifu_misalign_addr_o
);

    ifu_state_e                 r_state, w_state_nxt;
    logic [PORT_ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic                       r_kill, w_kill_nxt;

    logic [PORT_ADDR_WIDTH-1:0] r_pc_o;
    logic [PORT_DATA_WIDTH-1:0] r_inst_o;
    logic                       r_valid_o;

    logic                       w_req;
    logic                       w_deliver;
    logic [PORT_ADDR_WIDTH-1:0] w_dlv_pc;
    logic [PORT_DATA_WIDTH-1:0] w_dlv_inst;
    logic                       w_skid_load, w_skid_drain, w_skid_flush;
    logic                       w_skid_full;
    logic [PORT_ADDR_WIDTH-1:0] w_skid_pc;
    logic [PORT_DATA_WIDTH-1:0] w_skid_inst;
    logic [PORT_ADDR_WIDTH-1:0] w_jump_pc;

    assign w_jump_pc = align_word(ifu_jump_addr_i);

    ifu_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_flush (w_skid_flush),
        .i_pc    (r_pc),
        .i_inst  (ifu_mem_rdata_i),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_kill_nxt   = r_kill;
        w_req        = 1'b0;
        w_deliver    = 1'b0;
        w_dlv_pc     = r_pc;
        w_dlv_inst   = ifu_mem_rdata_i;
        w_skid_load  = 1'b0;
        w_skid_drain = 1'b0;
        w_skid_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (ifu_jump_flag_i) w_pc_nxt = w_jump_pc;
            end
            S_REQ: begin
                w_req = !ifu_jump_flag_i && !ifu_hold_flag_i;
                if (ifu_jump_flag_i) begin
                    w_pc_nxt = w_jump_pc;
                end else if (w_req && ifu_mem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ifu_mem_rvalid_i) begin
                    w_kill_nxt = 1'b0;
                    // A response to a pre-jump address is stale and must never reach IF/ID.
                    if (r_kill || ifu_jump_flag_i) begin
                        w_state_nxt = S_REQ;
                        if (ifu_jump_flag_i) w_pc_nxt = w_jump_pc;
                    end else if (ifu_hold_flag_i) begin
                        w_skid_load = 1'b1;
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = S_FULL;
                    end else begin
                        w_deliver   = 1'b1;
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = S_REQ;
                    end
                end else if (ifu_jump_flag_i) begin
                    w_pc_nxt   = w_jump_pc;
                    w_kill_nxt = 1'b1;
                end
            end
            S_FULL: begin
                if (ifu_jump_flag_i) begin
                    w_skid_flush = 1'b1;
                    w_pc_nxt     = w_jump_pc;
                    w_state_nxt  = S_REQ;
                end else if (!ifu_hold_flag_i) begin
                    w_skid_drain = w_skid_full;
                    w_deliver    = 1'b1;
                    w_dlv_pc     = w_skid_pc;
                    w_dlv_inst   = w_skid_inst;
                    w_state_nxt  = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Jump beats hold: the redirect bubble must appear even while ctrl is stalling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_o    <= '0;
            r_inst_o  <= INST_NOP;
            r_valid_o <= 1'b0;
        end else if (ifu_jump_flag_i) begin
            r_inst_o  <= INST_NOP;
            r_valid_o <= 1'b0;
        end else if (!ifu_hold_flag_i) begin
            if (w_deliver) begin
                r_pc_o    <= w_dlv_pc;
                r_inst_o  <= w_dlv_inst;
                r_valid_o <= 1'b1;
            end else begin
                r_inst_o  <= INST_NOP;
                r_valid_o <= 1'b0;
            end
        end
    end

    assign ifu_mem_req_o    = w_req;
    assign ifu_mem_addr_o   = r_pc;
    assign ifu_pc_o         = r_pc_o;
    assign ifu_inst_data_o  = r_inst_o;
    assign ifu_inst_valid_o = r_valid_o;

`ifdef IFU_MISALIGN_CHK_EN
    logic                       r_misalign;
    logic [PORT_ADDR_WIDTH-1:0] r_misalign_addr;
    logic                       w_misalign_hit;

    assign w_misalign_hit = ifu_jump_flag_i && (ifu_jump_addr_i != w_jump_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_misalign_hit;
            if (w_misalign_hit) r_misalign_addr <= ifu_jump_addr_i;
        end
    end

    assign ifu_misalign_o      = r_misalign;
    assign ifu_misalign_addr_o = r_misalign_addr;
`else
    assign ifu_misalign_o      = 1'b0;
    assign ifu_misalign_addr_o = '0;
`endif

endmodule
